// File: rtl/aes_pkg.sv
// Shared widths and bundle types for the AES-256 datapath.
// Constants only; no ports.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;
    localparam int AES_NBYTES_W        = 5;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    typedef struct packed {
        logic                    last;
        logic [AES_NBYTES_W-1:0] nbytes;
    } aes_blk_meta_t;

endpackage

// File: rtl/aes_byte_mask.sv
// Keeps the MSB-aligned valid bytes of a host word and zeroes the rest.
// Ports: bytes_i (0 = all 4 valid), word_i, word_o (masked word).
module aes_byte_mask
    import aes_pkg::*;
(
    input  logic [1:0] bytes_i,
    input  aes_word_t  word_i,
    output aes_word_t  word_o
);

    always_comb begin
        word_o = word_i;
        unique case (bytes_i)
            2'd1:    word_o = {word_i[31:24], 24'h0};
            2'd2:    word_o = {word_i[31:16], 16'h0};
            2'd3:    word_o = {word_i[31:8], 8'h0};
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/aes256_block_packer.sv
// Packs 32-bit host words into 128-bit blocks for aes256_fifo, zero-padding
// a short final block. Ports: clk, rst_n (sync, active-low); host side
// in_valid/in_ready/in_data/in_last/in_bytes; block side aes_in_valid/
// aes_in_ready/aes_in_block/aes_in_last/aes_in_nbytes.
module aes256_block_packer
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AES_WORD_W-1:0]   in_data,
    input  logic                    in_last,
    input  logic [1:0]              in_bytes,
    output logic                    aes_in_valid,
    input  logic                    aes_in_ready,
    output logic [AES_BLOCK_W-1:0]  aes_in_block,
    output logic                    aes_in_last,
    output logic [AES_NBYTES_W-1:0] aes_in_nbytes
);

    logic [95:0]   asm_q, asm_d;
    logic [1:0]    idx_q, idx_d;
    logic          asm_done_q, asm_done_d;
    aes_word_t     hold_q, hold_d;
    aes_blk_meta_t hold_meta_q, hold_meta_d;
    aes_block_t    out_blk_q, out_blk_d;
    aes_blk_meta_t out_meta_q, out_meta_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q;

    logic          accept;
    logic          complete;
    logic          drain;
    logic          out_free;
    logic [1:0]    eff_bytes;
    logic [2:0]    word_nb;
    aes_word_t     masked;
    aes_block_t    new_blk;
    aes_blk_meta_t new_meta;

    // in_bytes only matters on the final word of the message.
    assign eff_bytes = in_last ? in_bytes : 2'd0;

    aes_byte_mask u_mask (
        .bytes_i (eff_bytes),
        .word_i  (in_data),
        .word_o  (masked)
    );

    assign accept   = in_valid && in_ready_q;
    assign complete = accept && (idx_q == 2'd3 || in_last);
    assign drain    = out_valid_q && aes_in_ready;
    assign out_free = !out_valid_q || drain;

    assign word_nb = (eff_bytes == 2'd0) ? 3'd4 : {1'b0, eff_bytes};

    always_comb begin
        new_blk = '0;
        unique case (idx_q)
            2'd0: new_blk = {masked, 96'h0};
            2'd1: new_blk = {asm_q[95:64], masked, 64'h0};
            2'd2: new_blk = {asm_q[95:32], masked, 32'h0};
            2'd3: new_blk = {asm_q, masked};
        endcase
        new_meta.last   = in_last;
        new_meta.nbytes = {1'b0, idx_q, 2'b00} + {2'b00, word_nb};
    end

    always_comb begin
        asm_d       = asm_q;
        idx_d       = idx_q;
        asm_done_d  = asm_done_q;
        hold_d      = hold_q;
        hold_meta_d = hold_meta_q;
        out_blk_d   = out_blk_q;
        out_meta_d  = out_meta_q;
        out_valid_d = out_valid_q;

        if (accept && !complete) begin
            unique case (idx_q)
                2'd0:    asm_d[95:64] = in_data;
                2'd1:    asm_d[63:32] = in_data;
                2'd2:    asm_d[31:0]  = in_data;
                default: asm_d        = asm_q;
            endcase
            idx_d = idx_q + 2'd1;
        end

        if (drain) begin
            out_valid_d = 1'b0;
        end

        // in_ready is low while a block is held, so a held block and a
        // freshly completed one never coexist.
        if (asm_done_q) begin
            if (out_free) begin
                out_blk_d   = {asm_q, hold_q};
                out_meta_d  = hold_meta_q;
                out_valid_d = 1'b1;
                asm_done_d  = 1'b0;
                idx_d       = 2'd0;
            end
        end else if (complete) begin
            idx_d = 2'd0;
            if (out_free) begin
                out_blk_d   = new_blk;
                out_meta_d  = new_meta;
                out_valid_d = 1'b1;
            end else begin
                // Reuse the assembly register as the held block's top words.
                asm_d       = new_blk[127:32];
                hold_d      = new_blk[31:0];
                hold_meta_d = new_meta;
                asm_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q       <= '0;
            idx_q       <= '0;
            asm_done_q  <= 1'b0;
            hold_q      <= '0;
            hold_meta_q <= '0;
            out_blk_q   <= '0;
            out_meta_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            asm_done_q  <= asm_done_d;
            hold_q      <= hold_d;
            hold_meta_q <= hold_meta_d;
            out_blk_q   <= out_blk_d;
            out_meta_q  <= out_meta_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= !asm_done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign aes_in_valid  = out_valid_q;
    assign aes_in_block  = out_blk_q;
    assign aes_in_last   = out_meta_q.last;
    assign aes_in_nbytes = out_meta_q.nbytes;

endmodule
